// File: rtl/adder_result_accumulator.sv
// Accumulates a programmed number of adder_16bit results into a wrapping
// running total with a sticky overflow flag, using a valid/ready input handshake.
module adder_result_accumulator #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    output logic [WIDTH-1:0] acc,
    output logic             ovf,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [WIDTH:0]   sum_ext_s;

    // Next-state and datapath update; the adder is only evaluated on a handshake
    // so undefined sum_in values outside a handshake never reach the registers.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        count_d   = count_q;
        len_d     = len_q;
        sum_ext_s = {(WIDTH+1){1'b0}};
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    acc_d   = {WIDTH{1'b0}};
                    ovf_d   = 1'b0;
                    count_d = {CNT_W{1'b0}};
                    len_d   = len;
                    state_d = (len == {CNT_W{1'b0}}) ? S_DONE : S_RUN;
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    sum_ext_s = {1'b0, acc_q} + {1'b0, sum_in};
                    acc_d     = sum_ext_s[WIDTH-1:0];
                    ovf_d     = ovf_q | cout_in | sum_ext_s[WIDTH];
                    count_d   = count_q + CNT_ONE;
                    if (count_q == (len_q - CNT_ONE)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= {WIDTH{1'b0}};
            ovf_q   <= 1'b0;
            count_q <= {CNT_W{1'b0}};
            len_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    assign in_ready = (state_q == S_RUN);
    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign acc      = acc_q;
    assign ovf      = ovf_q;
    assign count    = count_q;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Self-checking bench for adder_result_accumulator: directed and randomized runs
// compared against an integer-arithmetic model of the running total.
module tb_adder_result_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] sum_in;
    logic        cout_in;
    logic [15:0] acc;
    logic        ovf;
    logic [7:0]  count;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] op_q[$];
    bit          co_q[$];
    int          gap_q[$];

    adder_result_accumulator #(.WIDTH(16), .CNT_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sum_in   (sum_in),
        .cout_in  (cout_in),
        .acc      (acc),
        .ovf      (ovf),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_ops();
        op_q.delete();
        co_q.delete();
        gap_q.delete();
    endtask

    task automatic push_op(input logic [15:0] op, input bit co);
        op_q.push_back(op);
        co_q.push_back(co);
    endtask

    // Pulses start; optionally offers an operand with cout=1 in the same cycle,
    // which must not be accepted.
    task automatic do_start(input int l, input bit with_valid);
        start    = 1'b1;
        len      = 8'(l);
        in_valid = with_valid;
        sum_in   = 16'h0055;
        cout_in  = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        cout_in  = 1'b0;
        check("start_busy",  32'(busy),  32'(l != 0));
        check("start_done",  32'(done),  32'(l == 0));
        check("start_count", 32'(count), 32'd0);
        check("start_acc",   32'(acc),   32'd0);
        check("start_ovf",   32'(ovf),   32'd0);
    endtask

    // Feeds every queued operand, with idle gaps from gap_q (or random gaps if
    // gap_q is empty), checking the running total against plain integer sums.
    task automatic run_ops();
        int  total;
        bit  any_co;
        int  n;
        int  gap;
        total  = 0;
        any_co = 1'b0;
        n      = op_q.size();
        for (int k = 0; k < n; k++) begin
            gap = (gap_q.size() > k) ? gap_q[k] : int'($urandom_range(0, 1));
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                sum_in   = 16'($urandom);
                cout_in  = 1'($urandom);
                tick();
                check("gap_ready", 32'(in_ready), 32'd1);
                check("gap_count", 32'(count), 32'(k));
            end
            in_valid = 1'b1;
            sum_in   = op_q[k];
            cout_in  = co_q[k];
            tick();
            in_valid = 1'b0;
            total    = total + int'(op_q[k]);
            any_co   = any_co | co_q[k];
            check("hs_count", 32'(count), 32'(k + 1));
            check("hs_acc",   32'(acc),   32'(total % 65536));
            check("hs_ovf",   32'(ovf),   32'(any_co || (total >= 65536)));
            if (k == n - 1) begin
                check("end_done",  32'(done),     32'd1);
                check("end_ready", 32'(in_ready), 32'd0);
                check("end_busy",  32'(busy),     32'd0);
            end else begin
                check("mid_done",  32'(done),     32'd0);
                check("mid_ready", 32'(in_ready), 32'd1);
            end
        end
        // Operands offered in DONE are ignored and the result holds.
        in_valid = 1'b1;
        sum_in   = 16'h1234;
        cout_in  = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        cout_in  = 1'b0;
        check("hold_acc",   32'(acc),   32'(total % 65536));
        check("hold_count", 32'(count), 32'(n));
        check("hold_ovf",   32'(ovf),   32'(any_co || (total >= 65536)));
        check("hold_done",  32'(done),  32'd1);
    endtask

    initial begin
        int rl;
        rst      = 1'b1;
        start    = 1'b0;
        len      = 8'd0;
        in_valid = 1'b0;
        sum_in   = 16'd0;
        cout_in  = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_acc",   32'(acc),      32'd0);
        check("rst_ovf",   32'(ovf),      32'd0);
        check("rst_count", 32'(count),    32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);

        // in_valid in IDLE is ignored.
        in_valid = 1'b1;
        sum_in   = 16'h0077;
        cout_in  = 1'b1;
        tick();
        in_valid = 1'b0;
        cout_in  = 1'b0;
        check("idle_count", 32'(count), 32'd0);
        check("idle_acc",   32'(acc),   32'd0);
        check("idle_ovf",   32'(ovf),   32'd0);
        check("idle_busy",  32'(busy),  32'd0);

        // Reset mid-run after 3 operands.
        do_start(5, 1'b0);
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            sum_in   = 16'h1111;
            cout_in  = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        cout_in  = 1'b0;
        check("pre_rst_count", 32'(count), 32'd3);
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("mrst_acc",   32'(acc),      32'd0);
        check("mrst_ovf",   32'(ovf),      32'd0);
        check("mrst_count", 32'(count),    32'd0);
        check("mrst_done",  32'(done),     32'd0);
        check("mrst_ready", 32'(in_ready), 32'd0);
        check("mrst_busy",  32'(busy),     32'd0);

        // Basic run.
        clear_ops();
        push_op(16'h0010, 1'b0);
        push_op(16'h0020, 1'b0);
        push_op(16'h0005, 1'b0);
        gap_q = '{0, 0, 0};
        do_start(3, 1'b0);
        run_ops();
        check("basic_acc", 32'(acc), 32'h0035);

        // Wrap produces overflow.
        clear_ops();
        push_op(16'hFFF0, 1'b0);
        push_op(16'h0020, 1'b0);
        gap_q = '{0, 0};
        do_start(2, 1'b0);
        run_ops();
        check("wrap_acc", 32'(acc), 32'h0010);
        check("wrap_ovf", 32'(ovf), 32'd1);

        // Adder carry-out alone sets overflow.
        clear_ops();
        push_op(16'h0001, 1'b1);
        gap_q = '{0};
        do_start(1, 1'b0);
        run_ops();
        check("cout_acc", 32'(acc), 32'h0001);
        check("cout_ovf", 32'(ovf), 32'd1);

        // Handshake gaps: valid pattern 1,0,0,1,1,0,1.
        clear_ops();
        for (int k = 1; k <= 4; k++) push_op(16'(k), 1'b0);
        gap_q = '{0, 2, 0, 1};
        do_start(4, 1'b0);
        run_ops();
        check("gaps_acc", 32'(acc), 32'h000A);

        // Empty run, then restart with a same-cycle operand that must be dropped.
        do_start(0, 1'b0);
        check("empty_acc", 32'(acc), 32'd0);
        clear_ops();
        push_op(16'd7, 1'b0);
        push_op(16'd9, 1'b0);
        gap_q = '{0, 0};
        do_start(2, 1'b1);
        run_ops();
        check("restart_acc", 32'(acc), 32'h0010);

        // Chained with the adder: a=i, b=j for j in 0..15.
        for (int i = 0; i < 16; i++) begin
            clear_ops();
            for (int j = 0; j < 16; j++) push_op(16'(i + j), 1'b0);
            do_start(16, 1'b0);
            run_ops();
            check("chain_acc", 32'(acc), 32'((16 * i + 120) % 65536));
            check("chain_ovf", 32'(ovf), 32'd0);
        end

        // Maximum length run with large random operands and rare carry-outs.
        clear_ops();
        for (int k = 0; k < 255; k++) push_op(16'($urandom), ($urandom_range(0, 63) == 0));
        do_start(255, 1'b0);
        run_ops();
        check("max_count", 32'(count), 32'd255);

        // Random short runs, mostly small operands so ovf stays low sometimes.
        for (int r = 0; r < 12; r++) begin
            clear_ops();
            rl = int'($urandom_range(1, 20));
            for (int k = 0; k < rl; k++) begin
                push_op((r % 2 == 0) ? 16'($urandom_range(0, 1000)) : 16'($urandom),
                        ($urandom_range(0, 31) == 0));
            end
            do_start(rl, r[0]);
            run_ops();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
